// File: rtl/blk_mem_gen.sv
// rtl/blk_mem_gen.sv - simple dual-port block RAM, read-first, defined output reset
// Optional second output register on port B when BLK_MEM_OUT_REG_EN is defined.
module blk_mem_gen #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32768
) (
    input  logic                  clka,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_q;
    logic                  w_wr_en;
    logic                  w_rd_in_range;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_wr_en       = ena & wea & ({1'b0, addra} < LP_DEPTH);
    assign w_rd_in_range = ({1'b0, addrb} < LP_DEPTH);
    assign w_rd_data     = w_rd_in_range ? r_mem[addrb] : '0;

    // Array is never cleared; rst_n only blocks writes while it is held low.
    always_ff @(posedge clka or negedge rst_n) begin
        if (rst_n) begin
            if (w_wr_en) begin
                r_mem[addra] <= dina;
            end
        end
    end

    // Nonblocking write above makes a same-edge collision read the old word.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_q <= '0;
        end else if (enb) begin
            r_rd_q <= w_rd_data;
        end
    end

`ifdef BLK_MEM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] r_out_q;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q <= '0;
        end else if (enb) begin
            r_out_q <= r_rd_q;
        end
    end

    assign doutb = r_out_q;
`else
    assign doutb = r_rd_q;
`endif

endmodule

// File: tb/tb_blk_mem_gen.sv
// tb/tb_blk_mem_gen.sv - self-checking bench for blk_mem_gen (honours BLK_MEM_OUT_REG_EN)
module tb_blk_mem_gen;

`ifdef BLK_MEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int AW    = 15;
    localparam int DW    = 8;
    localparam int DEPTH = 32768;

    logic          clka = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;

    int n_checks = 0;
    int n_fail   = 0;

    blk_mem_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clka (clka),
        .rst_n(rst_n),
        .ena  (ena),
        .wea  (wea),
        .addra(addra),
        .dina (dina),
        .enb  (enb),
        .addrb(addrb),
        .doutb(doutb)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
        string         name;
    } vec_t;

    typedef struct {
        logic [DW-1:0] v;
        bit            k;
    } rd_t;

    logic [DW-1:0] m_mem   [0:DEPTH-1];
    bit            m_known [0:DEPTH-1];
    rd_t           pq[$];
    logic [DW-1:0] samp [0:3];

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: doutb=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic xact(input vec_t t);
        ena = t.en; wea = 1'b1; addra = t.addr; dina = t.din; enb = 1'b0;
        step();
        ena = 1'b0; wea = 1'b0; enb = 1'b1; addrb = t.addr;
        repeat (LAT) step();
        check(t.name, doutb, t.exp);
        enb = 1'b0;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) a = AW'(DEPTH - 8) + a;
        return a;
    endfunction

    vec_t tbl[10];

    initial begin
        rd_t  r;
        rd_t  o;
        rst_n = 1'b0; ena = 1'b0; wea = 1'b0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;
        repeat (2) step();
        check("reset_state", doutb, 8'h00);
        rst_n = 1'b1;
        step();

        // write 0x65 @0, 0x8B @1, then back-to-back reads
        ena = 1'b1; wea = 1'b1; addra = 15'd0; dina = 8'h65; step();
        addra = 15'd1; dina = 8'h8B; step();
        ena = 1'b0; wea = 1'b0; enb = 1'b1;
        addrb = 15'd0; step(); samp[0] = doutb;
        addrb = 15'd1; step(); samp[1] = doutb;
        step(); samp[2] = doutb;
        check("wr_rd_first", samp[LAT-1], 8'h65);
        check("wr_rd_second", samp[LAT], 8'h8B);
        enb = 1'b0;

        tbl[0] = '{1'b1, 15'd2,      8'h3C, 8'h3C, "write_addr2"};
        tbl[1] = '{1'b0, 15'd2,      8'hAA, 8'h3C, "ena0_no_write"};
        tbl[2] = '{1'b1, 15'h7FFF,   8'hFF, 8'hFF, "top_ff"};
        tbl[3] = '{1'b1, 15'd0,      8'h00, 8'h00, "bottom_00"};
        tbl[4] = '{1'b0, 15'h7FFF,   8'h00, 8'hFF, "top_no_alias"};
        tbl[5] = '{1'b1, 15'h7FFF,   8'h00, 8'h00, "top_00"};
        tbl[6] = '{1'b1, 15'd0,      8'hFF, 8'hFF, "bottom_ff"};
        tbl[7] = '{1'b0, 15'h7FFF,   8'h11, 8'h00, "top_after_bottom"};
        tbl[8] = '{1'b1, 15'h4000,   8'hA5, 8'hA5, "mid_a5"};
        tbl[9] = '{1'b0, 15'd1,      8'h00, 8'h8B, "addr1_kept"};
        for (int i = 0; i < 10; i++) xact(tbl[i]);

        // read-first collision
        xact('{1'b1, 15'd5, 8'h11, 8'h11, "coll_init"});
        ena = 1'b1; wea = 1'b1; addra = 15'd5; dina = 8'h22; enb = 1'b1; addrb = 15'd5;
        step(); samp[0] = doutb;
        ena = 1'b0; wea = 1'b0;
        step(); samp[1] = doutb;
        step(); samp[2] = doutb;
        check("coll_old", samp[LAT-1], 8'h11);
        check("coll_new", samp[LAT], 8'h22);

        // enb low holds output while address and memory change
        enb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addrb = AW'(i * 3 + 1);
            ena = 1'b1; wea = 1'b1; addra = 15'd6; dina = 8'h5A;
            step();
            check("enb_hold", doutb, 8'h22);
        end
        ena = 1'b0; wea = 1'b0;

        // asynchronous reset mid-cycle, writes ignored while held
        #2 rst_n = 1'b0;
        #1 check("async_reset", doutb, 8'h00);
        ena = 1'b1; wea = 1'b1; addra = 15'd5; dina = 8'h77; enb = 1'b1; addrb = 15'd6;
        repeat (2) step();
        check("reset_hold", doutb, 8'h00);
        ena = 1'b0; wea = 1'b0; enb = 1'b0;
        rst_n = 1'b1;
        xact('{1'b0, 15'd5, 8'h00, 8'h22, "post_reset_5"});
        xact('{1'b0, 15'd6, 8'h00, 8'h5A, "post_reset_6"});

        // randomized traffic against array model with an output pipeline queue
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        pq.delete();
        for (int i = 0; i < LAT; i++) begin
            r.v = '0; r.k = 1'b0; pq.push_back(r);
        end
        for (int c = 0; c < 600; c++) begin
            ena = 1'($urandom_range(0, 1));
            wea = 1'($urandom_range(0, 1));
            enb = ($urandom_range(0, 3) != 0);
            addra = pick_addr();
            addrb = pick_addr();
            dina = DW'($urandom);
            r.v = m_mem[addrb];
            r.k = m_known[addrb];
            if (ena && wea) begin
                m_mem[addra] = dina;
                m_known[addra] = 1'b1;
            end
            if (enb) begin
                pq.push_back(r);
                void'(pq.pop_front());
            end
            step();
            o = pq[0];
            if (o.k) check("random", doutb, o.v);
        end
        ena = 1'b0; wea = 1'b0; enb = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
